adder_seq_ctrl: RTL and testbench

Multi-cycle sequencer that adds or subtracts wide W=N*M-bit operands using one shared N-bit adder_cla slice.
- Processes one N-bit slice per clock, LSB slice first, with the inter-slice carry held in a register.
- Sits between a valid/ready producer and consumer in the arithmetic datapath.
- Trades latency for area against a full-width carry-lookahead adder.

---
 rtl/adder_seq_ctrl_pkg.sv | 16 +
 rtl/adder_cla.sv | 30 +++
 rtl/adder_seq_ctrl.sv | 118 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_ctrl_pkg.sv
// Shared definitions for the sequenced slice adder: controller state encoding
// and the slice-index width helper.
package adder_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Slice index needs at least one bit even when there is a single slice.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/adder_cla.sv
// N-bit carry-lookahead adder slice; purely combinational.
module adder_cla #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_ci,
  output logic [N-1:0] o_s,
  output logic         o_co
);

  logic [N-1:0] w_g;
  logic [N-1:0] w_p;
  logic [N:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < N; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign o_s  = w_p ^ w_c[N-1:0];
  assign o_co = w_c[N];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract computed one N-bit slice per clock through a shared adder_cla,
// LSB slice first; valid/ready on both sides, result held in DONE until taken.
module adder_seq_ctrl
  import adder_seq_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*M-1:0]   in_a,
  input  logic [N*M-1:0]   in_b,
  input  logic             in_sub,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*M-1:0]   out_s,
  output logic             out_co,
  output logic             busy
);

  localparam int W  = N * M;
  localparam int IW = idx_width(M);
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_s;
  logic          r_co;
  logic          r_carry;
  logic [IW-1:0] r_idx;

  logic [N-1:0]  w_a_sl;
  logic [N-1:0]  w_b_sl;
  logic [N-1:0]  w_sum;
  logic          w_co;

  assign w_a_sl = r_a[r_idx*N +: N];
  assign w_b_sl = r_b[r_idx*N +: N];

  adder_cla #(.N(N)) u_slice (
    .i_a  (w_a_sl),
    .i_b  (w_b_sl),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_idx == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + ~borrow, so B and the carry are conditioned once at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_ci ^ in_sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_s[r_idx*N +: N] <= w_sum;
          r_carry           <= w_co;
          if (r_idx == LAST) begin
            r_co  <= w_co;
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_s  = r_s;
  assign out_co = r_co;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl at N=4, M=4.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        in_ci;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_s;
  logic        out_co;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  adder_seq_ctrl #(.N(4), .M(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present an operation and hold in_valid through the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic ci);
    int n = 0;
    in_a = a; in_b = b; in_sub = sub; in_ci = ci; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_ci = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    tests++;
    if ({out_co, out_s} !== 17'h0) begin
      fails++;
      $display("FAIL reset_result: got co=%b s=%h expected co=0 s=0000", out_co, out_s);
    end
  endtask

  task automatic test_add;
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_run_flags: got busy=%b rdy=%b expected busy=1 rdy=0", busy, in_ready);
    end
    wait_valid(lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL add_latency: got %0d cycles expected 4", lat);
    end
    tests++;
    if (out_s !== 16'h0000 || out_co !== 1'b1) begin
      fails++;
      $display("FAIL add_full_carry: got s=%h co=%b expected s=0000 co=1", out_s, out_co);
    end
    finish_op();
    start_op(16'h7FFF, 16'h0000, 1'b0, 1'b1);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'h8000 || out_co !== 1'b0 || lat !== 4) begin
      fails++;
      $display("FAIL add_carry_in: got s=%h co=%b lat=%0d expected s=8000 co=0 lat=4", out_s, out_co, lat);
    end
    finish_op();
  endtask

  task automatic test_sub;
    int lat;
    start_op(16'h1234, 16'h0235, 1'b1, 1'b0);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'h0FFF || out_co !== 1'b1) begin
      fails++;
      $display("FAIL sub_no_borrow: got s=%h co=%b expected s=0fff co=1", out_s, out_co);
    end
    finish_op();
    start_op(16'h0000, 16'h0001, 1'b1, 1'b0);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'hFFFF || out_co !== 1'b0) begin
      fails++;
      $display("FAIL sub_borrow: got s=%h co=%b expected s=ffff co=0", out_s, out_co);
    end
    finish_op();
    start_op(16'h0010, 16'h0001, 1'b1, 1'b1);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'h000E || out_co !== 1'b1) begin
      fails++;
      $display("FAIL sub_borrow_in: got s=%h co=%b expected s=000e co=1", out_s, out_co);
    end
    finish_op();
  endtask

  task automatic test_backpressure;
    int lat;
    int bad = 0;
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_valid(lat);
    in_a = 16'hAAAA; in_b = 16'h5555; in_sub = 1'b1; in_ci = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_s !== 16'h3333 || out_co !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, last s=%h co=%b rdy=%b vld=%b expected s=3333 co=0 rdy=0 vld=1",
               bad, out_s, out_co, in_ready, out_valid);
    end
    in_valid = 1'b0;
    finish_op();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    start_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'h1000 || out_co !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_op: got s=%h co=%b expected s=1000 co=0", out_s, out_co);
    end
    finish_op();
  endtask

  task automatic test_reset_mid;
    int lat;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_s !== 16'h0000 || out_co !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got rdy/vld/busy=%b s=%h co=%b expected 100 s=0000 co=0",
               {in_ready, out_valid, busy}, out_s, out_co);
    end
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_valid(lat);
    tests++;
    if (out_s !== 16'h0100 || out_co !== 1'b0 || lat !== 4) begin
      fails++;
      $display("FAIL reset_mid_next: got s=%h co=%b lat=%0d expected s=0100 co=0 lat=4", out_s, out_co, lat);
    end
    finish_op();
  endtask

  task automatic test_back_to_back;
    logic [15:0] a_v  [3] = '{16'h1234, 16'h8000, 16'hFFFF};
    logic [15:0] b_v  [3] = '{16'h4321, 16'h0001, 16'hFFFF};
    logic        sb_v [3] = '{1'b0, 1'b1, 1'b0};
    logic        ci_v [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] s_e  [3] = '{16'h5555, 16'h7FFF, 16'hFFFF};
    logic        co_e [3] = '{1'b0, 1'b1, 1'b1};
    int acc [3];
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = a_v[i]; in_b = b_v[i]; in_sub = sb_v[i]; in_ci = ci_v[i]; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      acc[i] = cyc;
      if (i == 2) in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      tests++;
      if (out_s !== s_e[i] || out_co !== co_e[i]) begin
        fails++;
        $display("FAIL b2b_result%0d: got s=%h co=%b expected s=%h co=%b", i, out_s, out_co, s_e[i], co_e[i]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (acc[i] - acc[i-1] != 6) begin
        fails++;
        $display("FAIL b2b_period%0d: got %0d cycles expected 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
